// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load encodings, bus widths and FSM states.
package wb_stage_pkg;

    localparam int unsigned RegBus     = 32;
    localparam int unsigned RegAddrBus = 5;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: selects the big-endian byte/half lane and sign/zero-extends.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned DW = RegBus
) (
    input  logic [2:0]    op,
    input  logic [1:0]    offset,
    input  logic [DW-1:0] word,
    output logic [DW-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Offset 0 is the most significant byte of the word.
        unique case (offset)
            2'd0: byte_lane = word[31:24];
            2'd1: byte_lane = word[23:16];
            2'd2: byte_lane = word[15:8];
            2'd3: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[15:0] : word[31:16];

        data = word;
        case (op)
            LOAD_LB:  data = {{(DW-8){byte_lane[7]}}, byte_lane};
            LOAD_LBU: data = {{(DW-8){1'b0}}, byte_lane};
            LOAD_LH:  data = {{(DW-16){half_lane[15]}}, half_lane};
            LOAD_LHU: data = {{(DW-16){1'b0}}, half_lane};
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results in one cycle and completes loads from the data memory.
// Optional combinational load-result forwarding is enabled with `define WB_LOAD_FWD_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DW = RegBus,
    parameter int unsigned AW = RegAddrBus
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wd,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_is_load,
    input  logic [2:0]    mem_load_op,
    input  logic [1:0]    mem_addr_lo,
    input  logic          dmem_rvalid,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          flush,
`ifdef WB_LOAD_FWD_EN
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_wd,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          ld_pend,
    output logic [AW-1:0] ld_pend_wd
);

    wb_state_e     state_q, state_d;
    logic          we_d;
    logic [AW-1:0] waddr_d;
    logic [DW-1:0] wdata_d;
    logic          ld_wreg_q, ld_wreg_d;
    logic [AW-1:0] ld_wd_q, ld_wd_d;
    logic [2:0]    ld_op_q, ld_op_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [DW-1:0] aligned;
    logic          xfer;

    wb_stage_load_align #(
        .DW(DW)
    ) u_align (
        .op    (ld_op_q),
        .offset(ld_off_q),
        .word  (dmem_rdata),
        .data  (aligned)
    );

    assign mem_ready  = rst && (state_q == StIdle);
    assign xfer       = mem_valid && mem_ready;
    assign ld_pend    = (state_q == StWait);
    assign ld_pend_wd = ld_wd_q;

`ifdef WB_LOAD_FWD_EN
    assign fwd_valid = (state_q == StWait) && dmem_rvalid && !flush && ld_wreg_q
                       && (ld_wd_q != '0);
    assign fwd_wd    = ld_wd_q;
    assign fwd_data  = aligned;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        waddr_d   = waddr;
        wdata_d   = wdata;
        ld_wreg_d = ld_wreg_q;
        ld_wd_d   = ld_wd_q;
        ld_op_d   = ld_op_q;
        ld_off_d  = ld_off_q;
        unique case (state_q)
            StIdle: begin
                if (xfer && !flush) begin
                    if (mem_is_load) begin
                        ld_wreg_d = mem_wreg;
                        ld_wd_d   = mem_wd;
                        ld_op_d   = mem_load_op;
                        ld_off_d  = mem_addr_lo;
                        state_d   = StWait;
                    end else begin
                        we_d    = mem_wreg && (mem_wd != '0);
                        waddr_d = mem_wd;
                        wdata_d = mem_wdata;
                    end
                end
            end
            StWait: begin
                if (flush) begin
                    // The response is still owed unless it arrives in this very cycle.
                    state_d = dmem_rvalid ? StIdle : StDrop;
                end else if (dmem_rvalid) begin
                    we_d    = ld_wreg_q && (ld_wd_q != '0);
                    waddr_d = ld_wd_q;
                    wdata_d = aligned;
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (dmem_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            ld_wreg_q <= 1'b0;
            ld_wd_q   <= '0;
            ld_op_q   <= LOAD_LW;
            ld_off_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            we        <= we_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            ld_wreg_q <= ld_wreg_d;
            ld_wd_q   <= ld_wd_d;
            ld_op_q   <= ld_op_d;
            ld_off_q  <= ld_off_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU retire, load alignment, flush and reset cases.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic          mem_wreg = 1'b0;
    logic [AW-1:0] mem_wd = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_is_load = 1'b0;
    logic [2:0]    mem_load_op = LOAD_LW;
    logic [1:0]    mem_addr_lo = 2'd0;
    logic          dmem_rvalid = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          flush = 1'b0;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ld_pend;
    logic [AW-1:0] ld_pend_wd;
`ifdef WB_LOAD_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_wd;
    logic [DW-1:0] fwd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .mem_is_load(mem_is_load),
        .mem_load_op(mem_load_op),
        .mem_addr_lo(mem_addr_lo),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .flush      (flush),
`ifdef WB_LOAD_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_wd     (fwd_wd),
        .fwd_data   (fwd_data),
`endif
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .ld_pend    (ld_pend),
        .ld_pend_wd (ld_pend_wd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic is_load, input logic wreg, input logic [AW-1:0] wd,
                         input logic [DW-1:0] wdat, input logic [2:0] op, input logic [1:0] off);
        mem_valid   = 1'b1;
        mem_is_load = is_load;
        mem_wreg    = wreg;
        mem_wd      = wd;
        mem_wdata   = wdat;
        mem_load_op = op;
        mem_addr_lo = off;
    endtask

    task automatic idle_inputs();
        mem_valid   = 1'b0;
        mem_is_load = 1'b0;
        mem_wreg    = 1'b0;
        flush       = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // Load with response 'lat' cycles after acceptance; checks interlock and the result write.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] off,
                           input logic [AW-1:0] wd, input logic [DW-1:0] rdata, input int lat,
                           input logic exp_we, input logic [DW-1:0] exp_data);
        issue(1'b1, 1'b1, wd, 32'h0, op, off);
        step();
        idle_inputs();
        for (int i = 1; i < lat; i++) begin
            check({tag, " wait ready"}, 32'(mem_ready), 32'd0);
            check({tag, " wait pend"}, 32'(ld_pend), 32'd1);
            check({tag, " wait pend_wd"}, 32'(ld_pend_wd), 32'(wd));
            check({tag, " wait we"}, 32'(we), 32'd0);
            step();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        check({tag, " resp ready"}, 32'(mem_ready), 32'd0);
`ifdef WB_LOAD_FWD_EN
        #1;
        check({tag, " fwd_valid"}, 32'(fwd_valid), 32'(exp_we));
        if (exp_we) check({tag, " fwd_data"}, fwd_data, exp_data);
`endif
        step();
        dmem_rvalid = 1'b0;
        check({tag, " we"}, 32'(we), 32'(exp_we));
        if (exp_we) begin
            check({tag, " waddr"}, 32'(waddr), 32'(wd));
            check({tag, " wdata"}, wdata, exp_data);
        end
        check({tag, " done ready"}, 32'(mem_ready), 32'd1);
        check({tag, " done pend"}, 32'(ld_pend), 32'd0);
        step();
        check({tag, " we pulse"}, 32'(we), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst ready", 32'(mem_ready), 32'd0);
        check("rst we", 32'(we), 32'd0);
        check("rst waddr", 32'(waddr), 32'd0);
        check("rst wdata", wdata, 32'd0);
        check("rst pend", 32'(ld_pend), 32'd0);
        check("rst pend_wd", 32'(ld_pend_wd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("idle ready", 32'(mem_ready), 32'd1);

        // 1: ALU retire
        issue(1'b0, 1'b1, 5'd5, 32'h1234, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        check("alu we", 32'(we), 32'd1);
        check("alu waddr", 32'(waddr), 32'd5);
        check("alu wdata", wdata, 32'h1234);
        step();
        check("alu we pulse", 32'(we), 32'd0);
        check("alu wdata hold", wdata, 32'h1234);

        // 2: byte loads
        do_load("lb", LOAD_LB, 2'd1, 5'd8, 32'h1180_2233, 3, 1'b1, 32'hFFFF_FF80);
        do_load("lbu", LOAD_LBU, 2'd1, 5'd8, 32'h1180_2233, 3, 1'b1, 32'h0000_0080);
        do_load("lb3", LOAD_LB, 2'd3, 5'd9, 32'h1180_22F3, 1, 1'b1, 32'hFFFF_FFF3);

        // 3: half/word loads, x0 destination
        do_load("lh", LOAD_LH, 2'd2, 5'd10, 32'hABCD_8001, 2, 1'b1, 32'hFFFF_8001);
        do_load("lhu0", LOAD_LHU, 2'd0, 5'd11, 32'hABCD_8001, 1, 1'b1, 32'h0000_ABCD);
        do_load("lw", LOAD_LW, 2'd3, 5'd12, 32'hABCD_8001, 1, 1'b1, 32'hABCD_8001);
        do_load("lw x0", LOAD_LW, 2'd0, 5'd0, 32'hABCD_8001, 2, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 5'd0, 32'h5555, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        check("alu x0 we", 32'(we), 32'd0);

        // 4: flush in WAIT, response arrives later and is dropped
        issue(1'b1, 1'b1, 5'd4, 32'h0, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("drop ready", 32'(mem_ready), 32'd0);
        check("drop pend", 32'(ld_pend), 32'd0);
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        check("drop resp ready", 32'(mem_ready), 32'd0);
        step();
        dmem_rvalid = 1'b0;
        check("drop we", 32'(we), 32'd0);
        check("drop done ready", 32'(mem_ready), 32'd1);
        issue(1'b0, 1'b1, 5'd3, 32'hDEAD, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        check("post drop we", 32'(we), 32'd1);
        check("post drop waddr", 32'(waddr), 32'd3);
        check("post drop wdata", wdata, 32'hDEAD);

        // 5: flush with response in the same cycle; flush with IDLE transfer
        issue(1'b1, 1'b1, 5'd6, 32'h0, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        flush       = 1'b1;
        dmem_rvalid = 1'b1;
        step();
        idle_inputs();
        check("fl+rv we", 32'(we), 32'd0);
        check("fl+rv ready", 32'(mem_ready), 32'd1);
        issue(1'b0, 1'b1, 5'd7, 32'h7777, LOAD_LW, 2'd0);
        flush = 1'b1;
        step();
        idle_inputs();
        check("fl idle we", 32'(we), 32'd0);
        check("fl idle waddr", 32'(waddr), 32'd3);
        check("fl idle ready", 32'(mem_ready), 32'd1);
        dmem_rvalid = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        check("idle rvalid we", 32'(we), 32'd0);
        check("idle rvalid ready", 32'(mem_ready), 32'd1);

        // 6: asynchronous reset while a write is visible, then while a load is pending
        issue(1'b0, 1'b1, 5'd2, 32'hBEEF, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        check("pre rst we", 32'(we), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async rst we", 32'(we), 32'd0);
        check("async rst waddr", 32'(waddr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        issue(1'b1, 1'b1, 5'd9, 32'h0, LOAD_LW, 2'd0);
        step();
        idle_inputs();
        check("pre rst pend", 32'(ld_pend), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async rst pend", 32'(ld_pend), 32'd0);
        check("async rst pend_wd", 32'(ld_pend_wd), 32'd0);
        check("async rst ready", 32'(mem_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post rst ready", 32'(mem_ready), 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        step();
        dmem_rvalid = 1'b0;
        check("stray rvalid we", 32'(we), 32'd0);
        check("stray rvalid pend", 32'(ld_pend), 32'd0);
        check("stray rvalid ready", 32'(mem_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
